// File: rtl/conv_result_writeback.sv
// Writes each kernel's conv result slice into the feature-map RAMs, optional ReLU and add-write.
// Latency: first strobe 1 cycle after start, done 2*PARA_KERNEL+1 cycles after start when RAMs are ready.
// Backpressure: after each strobe, waits (outputs held) until every RAM reports fm_write_ready.
module conv_result_writeback #(
  parameter int DATA_WIDTH       = 16,
  parameter int PARA_KERNEL      = 2,
  parameter int PARA_X           = 3,
  parameter int PARA_Y           = 3,
  parameter int WRITE_ADDR_WIDTH = 3
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              start,
  input  logic [PARA_KERNEL*PARA_X*PARA_Y*DATA_WIDTH-1:0]   result_data,
  input  logic [WRITE_ADDR_WIDTH-1:0]                       base_addr,
  input  logic [WRITE_ADDR_WIDTH-1:0]                       kernel_stride,
  input  logic                                              add_mode,
  input  logic                                              relu_en,
  input  logic [PARA_X-1:0]                                 fm_write_ready,
  output logic                                              fm_ena_wr,
  output logic                                              fm_ena_add_write,
  output logic [PARA_X*WRITE_ADDR_WIDTH-1:0]                fm_addr_write,
  output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]               fm_din,
  output logic                                              busy,
  output logic                                              done
);

  localparam int ELEMS   = PARA_X * PARA_Y;
  localparam int SLICE_W = ELEMS * DATA_WIDTH;
  localparam int KW      = (PARA_KERNEL > 1) ? $clog2(PARA_KERNEL) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(PARA_KERNEL - 1);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT, DONE} state_t;

  state_t                           state_q, state_d;
  logic [KW-1:0]                    k_q, k_d, k_inc;
  logic [PARA_KERNEL*SLICE_W-1:0]   res_q, res_d;
  logic [WRITE_ADDR_WIDTH-1:0]      stride_q, stride_d;
  logic [WRITE_ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic                             relu_q, relu_d;
  logic [SLICE_W-1:0]               din_q, din_d;
  logic                             ena_wr_d, add_wr_d, busy_d, done_d;

  // Sign bit set (negatives, -0, negative NaN) clamps the element to +0.
  function automatic logic [SLICE_W-1:0] apply_relu(input logic [SLICE_W-1:0] v, input logic en);
    logic [SLICE_W-1:0] r;
    r = v;
    for (int e = 0; e < ELEMS; e++) begin
      if (en && v[e*DATA_WIDTH + DATA_WIDTH - 1])
        r[e*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    k_inc    = k_q + 1'b1;
    res_d    = res_q;
    stride_d = stride_q;
    addr_d   = addr_q;
    relu_d   = relu_q;
    din_d    = din_q;
    ena_wr_d = 1'b0;
    add_wr_d = fm_ena_add_write;
    busy_d   = busy;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          res_d    = result_data;
          stride_d = kernel_stride;
          relu_d   = relu_en;
          add_wr_d = add_mode;
          k_d      = '0;
          addr_d   = base_addr;
          din_d    = apply_relu(result_data[SLICE_W-1:0], relu_en);
          ena_wr_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = WRITE;
        end
      end
      WRITE: state_d = WAIT;
      WAIT: begin
        if (&fm_write_ready) begin
          if (k_q != K_LAST) begin
            // Running sum wraps naturally at the address width.
            k_d      = k_inc;
            addr_d   = addr_q + stride_q;
            din_d    = apply_relu(res_q[int'(k_inc)*SLICE_W +: SLICE_W], relu_q);
            ena_wr_d = 1'b1;
            state_d  = WRITE;
          end else begin
            done_d   = 1'b1;
            busy_d   = 1'b0;
            add_wr_d = 1'b0;
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      k_q              <= '0;
      res_q            <= '0;
      stride_q         <= '0;
      addr_q           <= '0;
      relu_q           <= 1'b0;
      din_q            <= '0;
      fm_ena_wr        <= 1'b0;
      fm_ena_add_write <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      state_q          <= state_d;
      k_q              <= k_d;
      res_q            <= res_d;
      stride_q         <= stride_d;
      addr_q           <= addr_d;
      relu_q           <= relu_d;
      din_q            <= din_d;
      fm_ena_wr        <= ena_wr_d;
      fm_ena_add_write <= add_wr_d;
      busy             <= busy_d;
      done             <= done_d;
    end
  end

  assign fm_addr_write = {PARA_X{addr_q}};
  assign fm_din        = din_q;

endmodule
